master_resp_order: RTL and testbench
====================================

Name: master_resp_order

Overview:
- Per-master response ordering controller for the 4x4 crossbar; one instance per master port.
- Gates the master request toward the per-slave arbiters and detects acceptance from the arbiter grant plus slave ack.
- Records the target slave of each accepted request in an in-order FIFO and returns slave responses to the master strictly in issue order.
- Watchdog per head entry converts a lost response into an error response and discards the late response when it arrives.

Parameters:
- MASTER, 0, index of the owning master (0..3); grant code to match is MASTER+1.
- DEPTH, 4, max outstanding requests (power of 2, 2..16).
- DATA_W, 32, response data width.
- TIMEOUT, 64, cycles the head entry may wait before error (1..255).

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- master_req  in  1  request from master, held until master_ack
- master_addr  in  2  target slave index
- master_req_gated  out  1  request forwarded to arbiters: master_req && !full
- grant_id  in  12  arbiter grant codes, slave s at [3s+2:3s]; 0=none, 1..4=master
- slave_ack  in  4  per-slave ack
- master_ack  out  1  comb: master_req_gated && slave_ack[master_addr] && grant_id[master_addr]==MASTER+1
- slave_resp_valid  in  4  per-slave response valid, held until ready
- slave_resp_master  in  12  destination master code per slave, same encoding as grant_id
- slave_resp_data  in  4*DATA_W  per-slave response data
- slave_resp_ready  out  4  comb: response consumed this cycle
- master_resp_valid  out  1  registered, 1-cycle pulse
- master_resp_data  out  DATA_W  registered
- master_resp_err  out  1  registered, qualifies master_resp_valid
- outstanding  out  log2(DEPTH)+1  current FIFO count

Behaviour:
- Reset: FIFO pointers and count 0; watchdog 0; drop counters 0; master_resp_valid/err 0; master_resp_data 0; reset mid-transaction discards all entries with no response issued.
- Push: on master_ack, write master_addr at tail. full = (count==DEPTH) is evaluated on the current count, so no push occurs when full, even if a pop happens in the same cycle.
- Match (slave s): slave_resp_valid[s] && slave_resp_master[s]==MASTER+1.
- Drop: per-slave 4-bit drop_cnt[s]. When match and drop_cnt[s]>0:
  - assert slave_resp_ready[s] and discard the response;
  - decrement drop_cnt[s];
  - drop takes priority over head delivery for that slave.
- Deliver: when count>0, head slave h, match on h and drop_cnt[h]==0:
  - assert slave_resp_ready[h] and pop the head;
  - next cycle master_resp_valid=1, data=slave_resp_data[h], err=0.
- Other matches hold ready=0; the slave waits.
- Watchdog: counts cycles while count>0 and no pop occurs. It clears on pop or when count==0. When it reaches TIMEOUT:
  - pop the head and increment drop_cnt[h] (saturate at 15);
  - next cycle master_resp_valid=1, err=1, data=0.
- A timeout and a deliver on the same cycle cannot both occur; deliver wins and the watchdog clears.
- Simultaneous push and pop with count in 1..DEPTH-1: count unchanged, both pointers advance.
- Push while count==0: the entry becomes head next cycle; a response is not deliverable in the push cycle.
- Pointers wrap modulo DEPTH.
- At most one slave_resp_ready bit is set per cycle for deliver, plus any drop-cycle bits; each slave is independent.
- Latency: one cycle from slave_resp_ready to master_resp_valid.

Test Plan:
- MASTER=1: req addr=2, grant_id[8:6]=2, slave_ack[2]=1 → master_ack=1, outstanding=1. Then slave_resp_valid[2]=1, master code 2, data 0xA5A5_0001 → ready[2]=1 the same cycle, then master_resp_valid=1, data 0xA5A5_0001, err=0, outstanding=0.
- Ordering: issue to slave 3 then slave 0. Slave 0 responds first (held) → ready[0]=0 until slave 3 responds. Outputs appear in order slave3 then slave0, on consecutive cycles if both are valid.
- Full: DEPTH=4, 4 accepted requests with no responses → master_req_gated=0, master_ack=0 on the 5th request. A response and a new request in the same cycle → pop only; the request is accepted next cycle.
- Timeout: TIMEOUT=8, request to slave 1, no response → on the cycle after 8 waiting cycles, master_resp_valid=1, err=1, data=0, and drop_cnt[1]=1. A late slave 1 response is accepted (ready[1]=1), discarded with no master_resp_valid, and drop_cnt[1] returns to 0.
- Grant mismatch: slave_ack[0]=1 with grant_id[2:0]=3 while MASTER=1 → master_ack=0 and no push.
- Reset asserted with 3 outstanding → next cycle outstanding=0 and master_resp_valid=0. A subsequent stale response stays unconsumed (ready=0).

Source files
------------

// File: rtl/master_resp_order.sv
// master_resp_order: per-master in-order response tracker for the 4x4 crossbar,
// with a head-entry watchdog that turns lost responses into error replies.
module master_resp_order #(
    parameter int MASTER  = 0,
    parameter int DEPTH   = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    master_req,
    input  logic [1:0]              master_addr,
    output logic                    master_req_gated,
    input  logic [11:0]             grant_id,
    input  logic [3:0]              slave_ack,
    output logic                    master_ack,
    input  logic [3:0]              slave_resp_valid,
    input  logic [11:0]             slave_resp_master,
    input  logic [4*DATA_W-1:0]     slave_resp_data,
    output logic [3:0]              slave_resp_ready,
    output logic                    master_resp_valid,
    output logic [DATA_W-1:0]       master_resp_data,
    output logic                    master_resp_err,
    output logic [$clog2(DEPTH):0]  outstanding
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [2:0] CODE = 3'(MASTER + 1);

    logic [1:0]        fifo [DEPTH];
    logic [AW-1:0]     rd_ptr, wr_ptr;
    logic [AW:0]       count;
    logic [7:0]        wdog;
    logic [3:0]        drop_cnt [4];
    logic [2:0]        gnt [4];
    logic [2:0]        rsp_m [4];
    logic [DATA_W-1:0] rdata [4];
    logic [3:0]        match, drop;
    logic [1:0]        head;
    logic              deliver, timeout, pop, push;

    for (genvar s = 0; s < 4; s++) begin : g_slave
        assign gnt[s]   = grant_id[3*s +: 3];
        assign rsp_m[s] = slave_resp_master[3*s +: 3];
        assign rdata[s] = slave_resp_data[DATA_W*s +: DATA_W];
        assign match[s] = slave_resp_valid[s] && rsp_m[s] == CODE;
        // late responses owed to a timed-out entry are swallowed before any delivery
        assign drop[s]  = match[s] && drop_cnt[s] != 4'd0;
        assign slave_resp_ready[s] = drop[s] || (deliver && head == 2'(s));
    end

    assign outstanding      = count;
    assign master_req_gated = master_req && count != (AW+1)'(DEPTH);
    assign master_ack       = master_req_gated && slave_ack[master_addr] && gnt[master_addr] == CODE;
    assign push             = master_ack;
    assign head             = fifo[rd_ptr];
    assign deliver          = count != '0 && match[head] && drop_cnt[head] == 4'd0;
    assign timeout          = count != '0 && !deliver && wdog == 8'(TIMEOUT);
    assign pop              = deliver || timeout;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr            <= '0;
            wr_ptr            <= '0;
            count             <= '0;
            wdog              <= '0;
            master_resp_valid <= 1'b0;
            master_resp_err   <= 1'b0;
            master_resp_data  <= '0;
            for (int s = 0; s < 4; s++) drop_cnt[s] <= '0;
        end else begin
            if (push) begin
                fifo[wr_ptr] <= master_addr;
                wr_ptr       <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            wdog  <= (count == '0 || pop) ? '0 : wdog + 8'd1;
            // increment saturates at 15 unless a drop on the same slave frees a slot
            for (int s = 0; s < 4; s++)
                drop_cnt[s] <= drop_cnt[s] - 4'(drop[s])
                             + 4'(timeout && head == 2'(s) && (drop[s] || drop_cnt[s] != 4'hf));
            master_resp_valid <= pop;
            master_resp_err   <= timeout;
            master_resp_data  <= deliver ? rdata[head] : '0;
        end
    end
endmodule

// File: tb/tb_master_resp_order.sv
// tb_master_resp_order: directed scenario checks for master_resp_order (MASTER=1, DEPTH=4, TIMEOUT=8).
module tb_master_resp_order;
    logic         clk = 0;
    logic         reset;
    logic         master_req;
    logic [1:0]   master_addr;
    logic         master_req_gated;
    logic [11:0]  grant_id;
    logic [3:0]   slave_ack;
    logic         master_ack;
    logic [3:0]   slave_resp_valid;
    logic [11:0]  slave_resp_master;
    logic [127:0] slave_resp_data;
    logic [3:0]   slave_resp_ready;
    logic         master_resp_valid;
    logic [31:0]  master_resp_data;
    logic         master_resp_err;
    logic [2:0]   outstanding;
    int checks = 0;
    int failures = 0;

    master_resp_order #(.MASTER(1), .DEPTH(4), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .master_req(master_req), .master_addr(master_addr),
        .master_req_gated(master_req_gated), .grant_id(grant_id), .slave_ack(slave_ack),
        .master_ack(master_ack), .slave_resp_valid(slave_resp_valid),
        .slave_resp_master(slave_resp_master), .slave_resp_data(slave_resp_data),
        .slave_resp_ready(slave_resp_ready), .master_resp_valid(master_resp_valid),
        .master_resp_data(master_resp_data), .master_resp_err(master_resp_err),
        .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    task automatic clear_req();
        master_req = 0; master_addr = 0; grant_id = 0; slave_ack = 0;
    endtask

    task automatic clear_resp();
        slave_resp_valid = 0; slave_resp_master = 0; slave_resp_data = 0;
    endtask

    task automatic drive_req(input int a, input logic [2:0] code);
        master_req = 1; master_addr = 2'(a);
        grant_id[3*a +: 3] = code; slave_ack[a] = 1;
    endtask

    task automatic drive_resp(input int s, input logic [31:0] d);
        slave_resp_valid[s] = 1; slave_resp_master[3*s +: 3] = 3'd2; slave_resp_data[32*s +: 32] = d;
    endtask

    task automatic issue(input int a);
        @(negedge clk);
        drive_req(a, 3'd2);
        #1;
        checks++;
        if (master_ack !== 1'b1) begin failures++; $display("FAIL issue_ack addr=%0d got=%b exp=1", a, master_ack); end
        @(posedge clk); #1;
        clear_req();
    endtask

    task automatic respond(input int s, input logic [31:0] d);
        @(negedge clk);
        drive_resp(s, d);
        #1;
        checks++;
        if (slave_resp_ready !== 4'(1 << s)) begin failures++; $display("FAIL respond_ready s=%0d got=%b exp=%b", s, slave_resp_ready, 4'(1 << s)); end
        @(posedge clk); #1;
        checks++;
        if ({master_resp_valid, master_resp_err, master_resp_data} !== {2'b10, d}) begin
            failures++; $display("FAIL respond_out s=%0d got=%b/%b/%h exp=1/0/%h", s, master_resp_valid, master_resp_err, master_resp_data, d);
        end
        clear_resp();
    endtask

    task automatic test_reset();
        reset = 1; clear_req(); clear_resp();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({outstanding, master_resp_valid, master_resp_err, master_resp_data, master_req_gated} !== 38'd0) begin
            failures++; $display("FAIL reset_state got cnt=%0d v=%b e=%b d=%h g=%b exp all 0", outstanding, master_resp_valid, master_resp_err, master_resp_data, master_req_gated);
        end
        @(negedge clk); reset = 0;
    endtask

    task automatic test_basic();
        @(negedge clk);
        drive_req(2, 3'd2);
        #1;
        checks++;
        if ({master_req_gated, master_ack} !== 2'b11) begin failures++; $display("FAIL basic_ack got=%b exp=11", {master_req_gated, master_ack}); end
        @(posedge clk); #1;
        clear_req();
        checks++;
        if (outstanding !== 3'd1) begin failures++; $display("FAIL basic_outstanding got=%0d exp=1", outstanding); end
        respond(2, 32'hA5A5_0001);
        checks++;
        if (outstanding !== 3'd0) begin failures++; $display("FAIL basic_drain got=%0d exp=0", outstanding); end
        @(posedge clk); #1;
        checks++;
        if (master_resp_valid !== 1'b0) begin failures++; $display("FAIL basic_pulse got=%b exp=0", master_resp_valid); end
    endtask

    task automatic test_order();
        issue(3);
        issue(0);
        @(negedge clk);
        drive_resp(0, 32'h0000_00D0);
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (slave_resp_ready !== 4'b0000) begin failures++; $display("FAIL order_hold cyc=%0d got=%b exp=0000", i, slave_resp_ready); end
            @(negedge clk);
        end
        drive_resp(3, 32'h0000_00D3);
        #1;
        checks++;
        if (slave_resp_ready !== 4'b1000) begin failures++; $display("FAIL order_ready3 got=%b exp=1000", slave_resp_ready); end
        @(posedge clk); #1;
        checks++;
        if ({master_resp_valid, master_resp_err, master_resp_data} !== {2'b10, 32'hD3}) begin
            failures++; $display("FAIL order_first got=%b/%b/%h exp=1/0/000000d3", master_resp_valid, master_resp_err, master_resp_data);
        end
        slave_resp_valid[3] = 0;
        @(negedge clk); #1;
        checks++;
        if (slave_resp_ready !== 4'b0001) begin failures++; $display("FAIL order_ready0 got=%b exp=0001", slave_resp_ready); end
        @(posedge clk); #1;
        checks++;
        if ({master_resp_valid, master_resp_err, master_resp_data} !== {2'b10, 32'hD0}) begin
            failures++; $display("FAIL order_second got=%b/%b/%h exp=1/0/000000d0", master_resp_valid, master_resp_err, master_resp_data);
        end
        clear_resp();
    endtask

    task automatic test_full();
        for (int a = 0; a < 4; a++) issue(a);
        checks++;
        if (outstanding !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", outstanding); end
        @(negedge clk);
        drive_req(1, 3'd2);
        #1;
        checks++;
        if ({master_req_gated, master_ack} !== 2'b00) begin failures++; $display("FAIL full_gate got=%b exp=00", {master_req_gated, master_ack}); end
        @(posedge clk); #1;
        checks++;
        if (outstanding !== 3'd4) begin failures++; $display("FAIL full_nopush got=%0d exp=4", outstanding); end
        @(negedge clk);
        drive_resp(0, 32'h0000_0F00);
        #1;
        checks++;
        if ({slave_resp_ready, master_ack} !== 5'b0001_0) begin failures++; $display("FAIL full_pop_only got=%b exp=00010", {slave_resp_ready, master_ack}); end
        @(posedge clk); #1;
        checks++;
        if ({outstanding, master_resp_valid} !== {3'd3, 1'b1}) begin failures++; $display("FAIL full_popped got=%0d/%b exp=3/1", outstanding, master_resp_valid); end
        @(negedge clk);
        clear_resp();
        #1;
        checks++;
        if (master_ack !== 1'b1) begin failures++; $display("FAIL full_retry got=%b exp=1", master_ack); end
        @(posedge clk); #1;
        clear_req();
        checks++;
        if (outstanding !== 3'd4) begin failures++; $display("FAIL full_refill got=%0d exp=4", outstanding); end
        respond(1, 32'h0000_0F01);
        respond(2, 32'h0000_0F02);
        respond(3, 32'h0000_0F03);
        respond(1, 32'h0000_0F11);
    endtask

    task automatic test_timeout();
        bit early = 0;
        issue(1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (master_resp_valid) early = 1;
        end
        checks++;
        if (early) begin failures++; $display("FAIL timeout_early got=1 exp=0"); end
        @(posedge clk); #1;
        checks++;
        if ({master_resp_valid, master_resp_err, master_resp_data, outstanding} !== {2'b11, 32'd0, 3'd0}) begin
            failures++; $display("FAIL timeout_err got=%b/%b/%h cnt=%0d exp=1/1/00000000 cnt=0", master_resp_valid, master_resp_err, master_resp_data, outstanding);
        end
        checks++;
        if (dut.drop_cnt[1] !== 4'd1) begin failures++; $display("FAIL timeout_dropcnt got=%0d exp=1", dut.drop_cnt[1]); end
        @(negedge clk);
        drive_resp(1, 32'h0000_1A7E);
        #1;
        checks++;
        if (slave_resp_ready !== 4'b0010) begin failures++; $display("FAIL late_ready got=%b exp=0010", slave_resp_ready); end
        @(posedge clk); #1;
        clear_resp();
        checks++;
        if ({master_resp_valid, dut.drop_cnt[1]} !== 5'b0_0000) begin failures++; $display("FAIL late_discard got=%b/%0d exp=0/0", master_resp_valid, dut.drop_cnt[1]); end
    endtask

    task automatic test_grant_mismatch();
        @(negedge clk);
        drive_req(0, 3'd3);
        #1;
        checks++;
        if ({master_req_gated, master_ack} !== 2'b10) begin failures++; $display("FAIL mismatch_ack got=%b exp=10", {master_req_gated, master_ack}); end
        @(posedge clk); #1;
        clear_req();
        checks++;
        if (outstanding !== 3'd0) begin failures++; $display("FAIL mismatch_push got=%0d exp=0", outstanding); end
    endtask

    task automatic test_reset_mid();
        for (int a = 0; a < 3; a++) issue(a);
        checks++;
        if (outstanding !== 3'd3) begin failures++; $display("FAIL rmid_count got=%0d exp=3", outstanding); end
        @(negedge clk); reset = 1;
        @(posedge clk); #1;
        checks++;
        if ({outstanding, master_resp_valid} !== 4'd0) begin failures++; $display("FAIL rmid_clear got=%0d/%b exp=0/0", outstanding, master_resp_valid); end
        @(negedge clk);
        reset = 0;
        drive_resp(0, 32'h0000_57A1);
        #1;
        checks++;
        if (slave_resp_ready !== 4'b0000) begin failures++; $display("FAIL rmid_stale got=%b exp=0000", slave_resp_ready); end
        @(posedge clk); #1;
        checks++;
        if (master_resp_valid !== 1'b0) begin failures++; $display("FAIL rmid_noresp got=%b exp=0", master_resp_valid); end
        clear_resp();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=stuck exp=finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_order();
        test_full();
        test_timeout();
        test_grant_mismatch();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
